dpcm_encoder_param: RTL and testbench
=====================================

// Module: dpcm_encoder_param
// PURPOSE
//  Parametrised streaming DPCM encoder, successor to the fixed 800x600 RGB888->RGB565 compressor.
//  - Takes one pixel per accepted beat: CH channels, each CW bits wide.
//  - Predicts each channel in one of 4 selectable modes.
//  - Quantises the residual per channel and emits a packed code word.
//  - Tracks the decoder's reconstructed image in a circular line buffer so encoder and decoder stay in lockstep.
//  - Sits between the pixel generator and the frame packer/SDRAM writer; full valid/ready on both sides.
// PARAMETERS
//  IMG_W  800      pixels per line (>=2)
//  IMG_H  600      lines per frame (>=2)
//  CH     3        channels per pixel; channel 0 = MSBs of i_data
//  CW     8        bits per input channel
//  QSH    {3,2,3}  per-channel quantisation shift, CH x 4b packed, channel 0 first; each < CW
//  OW     derived  sum over channels of (CW-QSH[c]); 16 for the defaults
// PORTS
//  i_clk      in   1       clock
//  i_rst_n    in   1       asynchronous, active-low reset
//  i_mode     in   2       predictor: 0 bypass, 1 left, 2 up, 3 average; latched on accepted SOF beat
//  i_valid    in   1       input pixel valid
//  o_ready    out  1       encoder can accept a pixel
//  i_sof      in   1       qualifies the current input beat as pixel (0,0)
//  i_data     in   CH*CW   input pixel
//  o_valid    out  1       code word valid
//  i_ready    in   1       downstream accepts the code word
//  o_data     out  OW      packed codes, channel 0 in the MSBs
//  o_sof      out  1       code word is pixel (0,0)
//  o_eol      out  1       code word is the last pixel of a line
//  o_eof      out  1       code word is the last pixel of the frame
// BEHAVIOUR
//  - Reset values: o_valid=0, o_data=0, o_sof/o_eol/o_eof=0.
//    Internal state: col=0, row=0, mode_q=3, left-pixel register=0. Line-buffer RAM is not reset.
//  - Handshake:
//    - o_ready = !o_valid | i_ready (single output register, no bubble at full rate).
//    - A pixel is accepted when i_valid & o_ready. The output register loads 1 cycle later; latency is 1 cycle.
//    - While o_valid & !i_ready: o_data and all flags hold stable; no input is accepted.
//  - Position:
//    - col/row advance only on accept. col wraps at IMG_W-1 -> 0 with row+1; row wraps at IMG_H-1 -> 0.
//    - An accepted beat with i_sof=1 forces position (0,0) and latches i_mode into mode_q, at any position.
//  - Prediction per channel (MID = 2^(CW-1)-1):
//    - L = previous reconstructed pixel on this row; MID when col==0.
//    - U = reconstructed pixel at the same col on the row above; MID when row==0.
//    - mode 0: P=0. mode 1: P=L. mode 2: P=U. mode 3: P=floor((L+U)/2), sum taken CW+1 bits wide.
//  - Residual per channel:
//    - d = pix - P, signed CW+1 bits.
//    - Clamp d to [-2^(CW-1), 2^(CW-1)-1].
//    - code = d >>> QSH[c], two's complement, CW-QSH[c] bits.
//    - Mode 0 exception: code = pix >> QSH[c], unsigned.
//  - Reconstruction: R = (P + (sign-extended code << QSH[c])) mod 2^CW.
//    - Wrap-around is intentional and mirrors the decoder.
//    - R is written to the line buffer at col and to the left register, on accept only.
//  - Line buffer:
//    - IMG_W x CH*CW circular RAM indexed by col (not a shift chain).
//    - Read of U and write of R at the same address in the same cycle: read returns the old value (row above).
//  - Flags:
//    - o_sof = position (0,0).
//    - o_eol = col==IMG_W-1.
//    - o_eof = col==IMG_W-1 & row==IMG_H-1.
//    - All flags are registered together with o_data.
//  - A mode change takes effect only at the next accepted SOF beat.
//  - Asynchronous reset mid-frame clears o_valid immediately. The next frame must start with i_sof.
// TESTING
//  - mode 3, SOF pixel 0x808080 -> o_data 0x0000, o_sof=1; reconstructed 0x7F7F7F.
//  - mode 3, SOF pixel 0xFF0000 -> diff clamps -> o_data 0x7C10 (R=0F, G=20, B=10).
//  - mode 0, pixel 0xFFFFFF -> o_data 0xFFFF; pixel 0x000000 -> 0x0000.
//  - IMG_W=4, IMG_H=3, random pixels, modes 1/2/3:
//    - matches golden C model;
//    - o_eol at col 3, o_eof on beat 12;
//    - beat 13 is treated as (0,0) with o_sof=1.
//  - Random i_ready low bursts (1-5 cycles):
//    - o_data stable while stalled;
//    - no pixel lost or duplicated;
//    - output stream identical to the i_ready=1 run.
//  - i_sof at (2,1) -> codes use MID predictors from there on.
//    Reset asserted mid-line -> o_valid=0 within the same cycle.

Source files
------------

// File: rtl/dpcm_encoder_param.sv
// dpcm_encoder_param
//   Streaming DPCM encoder. Each accepted beat carries one pixel of CH channels,
//   CW bits each. Every channel is predicted from the decoder-side reconstruction
//   (left neighbour, pixel above, or their average). The residual is clamped and
//   quantised to CW-QSH[c] bits, and the codes are packed into one word with
//   channel 0 in the MSBs. The reconstruction is stored in a left-pixel register
//   and in a one-line circular buffer, so the encoder tracks exactly what the
//   decoder will see.
//
// Ports
//   i_clk, i_rst_n  clock; asynchronous active-low reset
//   i_mode          predictor: 0 bypass, 1 left, 2 up, 3 average. Latched on an
//                   accepted SOF beat.
//   i_valid/o_ready input handshake
//   i_sof           this input beat is pixel (0,0)
//   i_data          input pixel, CH*CW bits, channel 0 in the MSBs
//   o_valid/i_ready output handshake
//   o_data          packed codes, OW bits, channel 0 in the MSBs
//   o_sof/o_eol/o_eof  position flags, registered with o_data

package dpcm_encoder_param_pkg;
  // Quantisation shift of channel c; channel 0 sits in the top nibble.
  function automatic int qsh_of(input logic [63:0] qsh, input int ch, input int c);
    return 32'(qsh[(ch-1-c)*4 +: 4]);
  endfunction

  // Bit position of channel c's code inside the packed word.
  function automatic int code_lsb(input logic [63:0] qsh, input int ch, input int cw,
                                  input int c);
    int s;
    s = 0;
    for (int k = c + 1; k < ch; k++) s += cw - qsh_of(qsh, ch, k);
    return s;
  endfunction

  function automatic int code_width(input logic [63:0] qsh, input int ch, input int cw);
    return code_lsb(qsh, ch, cw, -1);
  endfunction
endpackage

module dpcm_encoder_param #(
  parameter int               IMG_W = 800,
  parameter int               IMG_H = 600,
  parameter int               CH    = 3,
  parameter int               CW    = 8,
  parameter logic [CH*4-1:0]  QSH   = 12'h323,
  localparam int              OW    = dpcm_encoder_param_pkg::code_width(64'(QSH), CH, CW)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [1:0]          i_mode,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_sof,
  input  logic [CH*CW-1:0]    i_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [OW-1:0]       o_data,
  output logic                o_sof,
  output logic                o_eol,
  output logic                o_eof
);

  localparam int COLW = $clog2(IMG_W);
  localparam int ROWW = $clog2(IMG_H);
  localparam logic [COLW-1:0] LAST_COL = COLW'(IMG_W - 1);
  localparam logic [ROWW-1:0] LAST_ROW = ROWW'(IMG_H - 1);
  localparam logic [CW-1:0]   MID = CW'((1 << (CW - 1)) - 1);
  localparam logic signed [CW:0] DMAX = (CW+1)'((1 << (CW - 1)) - 1);
  localparam logic signed [CW:0] DMIN = ~DMAX;

  function automatic logic signed [CW:0] sat_res(input logic signed [CW:0] d);
    if (d > DMAX) return DMAX;
    if (d < DMIN) return DMIN;
    return d;
  endfunction

  logic [COLW-1:0]     col_q, col_p0;
  logic [ROWW-1:0]     row_q, row_p0;
  logic [1:0]          mode_q, mode_p0;
  logic [CH*CW-1:0]    left_q;
  logic [CH*CW-1:0]    up_p0;
  logic [CH*CW-1:0]    recon_p0;
  logic [OW-1:0]       code_p0;
  logic                first_col_p0, first_row_p0;
  logic                accept;
  logic [CH*CW-1:0]    line_buf [IMG_W];

  assign o_ready = ~o_valid | i_ready;
  assign accept  = i_valid & o_ready;

  // An SOF beat is pixel (0,0) and carries its own mode, whatever the counters say.
  assign col_p0       = i_sof ? '0 : col_q;
  assign row_p0       = i_sof ? '0 : row_q;
  assign mode_p0      = i_sof ? i_mode : mode_q;
  assign first_col_p0 = (col_p0 == '0);
  assign first_row_p0 = (row_p0 == '0);

  // Read happens before the write at the clock edge, so this is the row above.
  assign up_p0 = line_buf[col_p0];

  for (genvar c = 0; c < CH; c++) begin : g_ch
    localparam int SH  = dpcm_encoder_param_pkg::qsh_of(64'(QSH), CH, c);
    localparam int CB  = CW - SH;
    localparam int LSB = dpcm_encoder_param_pkg::code_lsb(64'(QSH), CH, CW, c);

    logic [CW-1:0]        pix, l, u, p, r;
    logic [CW:0]          sum;
    logic signed [CW:0]   d, dsat;
    logic [CB-1:0]        code;

    always_comb begin
      pix = i_data[(CH-1-c)*CW +: CW];
      l   = first_col_p0 ? MID : left_q[(CH-1-c)*CW +: CW];
      u   = first_row_p0 ? MID : up_p0[(CH-1-c)*CW +: CW];
      sum = {1'b0, l} + {1'b0, u};
      case (mode_p0)
        2'd0:    p = '0;
        2'd1:    p = l;
        2'd2:    p = u;
        default: p = CW'(sum >> 1);
      endcase
      d    = $signed({1'b0, pix}) - $signed({1'b0, p});
      dsat = sat_res(d);
      // Bypass sends the plain truncated pixel; the others send a signed residual.
      if (mode_p0 == 2'd0) code = pix[CW-1:SH];
      else                 code = CB'(dsat >>> SH);
      // The upper bits of a sign-extended code drop out modulo 2^CW, so zero
      // extension yields the same wrapped reconstruction as the decoder.
      r = p + (CW'(code) << SH);
    end

    assign code_p0[LSB +: CB]           = code;
    assign recon_p0[(CH-1-c)*CW +: CW]  = r;
  end

  // ---- stage boundary: accept -> output register ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sof   <= 1'b0;
      o_eol   <= 1'b0;
      o_eof   <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      mode_q  <= 2'd3;
      left_q  <= '0;
    end else begin
      if (o_ready) o_valid <= i_valid;
      if (accept) begin
        o_data <= code_p0;
        o_sof  <= first_col_p0 & first_row_p0;
        o_eol  <= (col_p0 == LAST_COL);
        o_eof  <= (col_p0 == LAST_COL) & (row_p0 == LAST_ROW);
        left_q <= recon_p0;
        mode_q <= mode_p0;
        if (col_p0 == LAST_COL) begin
          col_q <= '0;
          row_q <= (row_p0 == LAST_ROW) ? '0 : row_p0 + ROWW'(1);
        end else begin
          col_q <= col_p0 + COLW'(1);
          row_q <= row_p0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) line_buf[col_p0] <= recon_p0;
  end

endmodule

// File: tb/tb_dpcm_encoder_param.sv
// Testbench for dpcm_encoder_param with a 4x3 image, 3 channels of 8 bits and
// shifts {3,2,3} (16-bit codes).
module tb_dpcm_encoder_param;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = 13;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_mode;
  logic        in_valid;
  logic        rdy_out;
  logic        in_sof;
  logic [23:0] in_data;
  logic        out_valid;
  logic        ds_ready;
  logic [15:0] out_data;
  logic        out_sof, out_eol, out_eof;

  dpcm_encoder_param #(.IMG_W(W), .IMG_H(H), .CH(3), .CW(8), .QSH(12'h323)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(in_mode), .i_valid(in_valid),
    .o_ready(rdy_out), .i_sof(in_sof), .i_data(in_data), .o_valid(out_valid),
    .i_ready(ds_ready), .o_data(out_data), .o_sof(out_sof), .o_eol(out_eol),
    .o_eof(out_eof)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [23:0] pix_mem [N];
  logic [18:0] ref_out [N];
  logic [18:0] exp_q [$];

  // Reference model state: reconstructed line and left pixel.
  int up_m [W][3];
  int left_m [3];
  int mcol, mrow, mmode;

  task automatic model_beat(input logic [23:0] pix, input bit sof, input int mode,
                            output logic [18:0] exp_v);
    int px, l, u, p, d, q, sh, w, r;
    logic [15:0] code;
    bit fs, fe, ff;
    if (sof) begin
      mcol = 0; mrow = 0; mmode = mode;
    end
    code = '0;
    for (int c = 0; c < 3; c++) begin
      sh = (c == 1) ? 2 : 3;
      w  = 8 - sh;
      px = int'((pix >> (16 - 8 * c)) & 24'hFF);
      l  = (mcol == 0) ? 127 : left_m[c];
      u  = (mrow == 0) ? 127 : up_m[mcol][c];
      case (mmode)
        0:       p = 0;
        1:       p = l;
        2:       p = u;
        default: p = (l + u) / 2;
      endcase
      if (mmode == 0) begin
        q = px >> sh;
        r = (q << sh) & 255;
      end else begin
        d = px - p;
        if (d > 127)  d = 127;
        if (d < -128) d = -128;
        if (d >= 0) q = d / (1 << sh);
        else        q = -((-d + (1 << sh) - 1) / (1 << sh));
        r = (p + q * (1 << sh)) & 255;
      end
      q = q & ((1 << w) - 1);
      code = (code << w) | 16'(q);
      left_m[c] = r;
      up_m[mcol][c] = r;
    end
    fs = (mcol == 0) && (mrow == 0);
    fe = (mcol == W - 1);
    ff = fe && (mrow == H - 1);
    exp_v = {code, fs, fe, ff};
    if (mcol == W - 1) begin
      mcol = 0;
      mrow = (mrow == H - 1) ? 0 : mrow + 1;
    end else begin
      mcol = mcol + 1;
    end
  endtask

  // Drives one beat at a negedge; its output is visible at the following negedge.
  task automatic send_one(input logic [23:0] pix, input bit sof, input logic [1:0] md);
    @(negedge clk);
    in_valid = 1'b1; in_sof = sof; in_data = pix; in_mode = md;
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_mode = 2'd0; in_data = '0;
    ds_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== 16'h0000) begin
      errors++; $display("FAIL reset_data: got %h want 0000", out_data);
    end
    checks++;
    if ({out_sof, out_eol, out_eof} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {out_sof, out_eol, out_eof});
    end
    checks++;
    if (rdy_out !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", rdy_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    ds_ready = 1'b1;
    send_one(24'h808080, 1'b1, 2'd3);
    checks++;
    if ({out_valid, out_data, out_sof, out_eol, out_eof} !== {1'b1, 16'h0000, 3'b100}) begin
      errors++; $display("FAIL vec_mid_m3: got %h want %h",
        {out_valid, out_data, out_sof, out_eol, out_eof}, {1'b1, 16'h0000, 3'b100});
    end
    send_one(24'hFF0000, 1'b1, 2'd3);
    checks++;
    if ({out_valid, out_data, out_sof} !== {1'b1, 16'h7C10, 1'b1}) begin
      errors++; $display("FAIL vec_clamp_m3: got %h want %h",
        {out_valid, out_data, out_sof}, {1'b1, 16'h7C10, 1'b1});
    end
    send_one(24'hFFFFFF, 1'b1, 2'd0);
    checks++;
    if ({out_valid, out_data, out_sof} !== {1'b1, 16'hFFFF, 1'b1}) begin
      errors++; $display("FAIL vec_white_m0: got %h want %h",
        {out_valid, out_data, out_sof}, {1'b1, 16'hFFFF, 1'b1});
    end
    send_one(24'h000000, 1'b0, 2'd0);
    checks++;
    if ({out_valid, out_data, out_sof, out_eol, out_eof} !== {1'b1, 16'h0000, 3'b000}) begin
      errors++; $display("FAIL vec_black_m0: got %h want %h",
        {out_valid, out_data, out_sof, out_eol, out_eof}, {1'b1, 16'h0000, 3'b000});
    end
  endtask

  // Left prediction must use the reconstructed 0x7F, and i_mode without SOF is ignored.
  task automatic test_mode_hold();
    ds_ready = 1'b1;
    send_one(24'h808080, 1'b1, 2'd1);
    checks++;
    if (out_data !== 16'h0000) begin
      errors++; $display("FAIL hold_first: got %h want 0000", out_data);
    end
    send_one(24'h878787, 1'b0, 2'd0);
    checks++;
    if ({out_data, out_sof} !== {16'h0841, 1'b0}) begin
      errors++; $display("FAIL hold_left_recon: got %h want %h",
        {out_data, out_sof}, {16'h0841, 1'b0});
    end
  endtask

  task automatic test_frame(input int mode, input bit record);
    int sent, got, cyc;
    logic [18:0] obs, e;
    sent = 0; got = 0; cyc = 0;
    exp_q.delete();
    ds_ready = 1'b1;
    while ((sent < N || got < sent) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        obs = {out_data, out_sof, out_eol, out_eof};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL frame_m%0d_extra: got %h want no output", mode, obs);
        end else begin
          if (obs !== exp_q[0]) begin
            errors++; $display("FAIL frame_m%0d_beat%0d: got %h want %h", mode, got, obs, exp_q[0]);
          end
          if (record) ref_out[got] = obs;
          void'(exp_q.pop_front());
          got++;
        end
      end
      if (sent < N) begin
        in_valid = 1'b1; in_sof = (sent == 0); in_data = pix_mem[sent]; in_mode = 2'(mode);
        model_beat(pix_mem[sent], sent == 0, mode, e);
        exp_q.push_back(e);
        sent++;
      end else begin
        in_valid = 1'b0; in_sof = 1'b0;
      end
    end
    in_valid = 1'b0; in_sof = 1'b0;
    checks++;
    if (got != N) begin
      errors++; $display("FAIL frame_m%0d_count: got %0d outputs want %0d", mode, got, N);
    end
  endtask

  task automatic test_stall();
    int sent, got, cyc, stall;
    bit rdy;
    logic [18:0] obs;
    sent = 0; got = 0; cyc = 0; stall = 0;
    while ((sent < N || got < N) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (stall > 0) begin
        rdy = 1'b0; stall--;
      end else if ($urandom_range(0, 2) == 0) begin
        rdy = 1'b0; stall = $urandom_range(0, 4);
      end else begin
        rdy = 1'b1;
      end
      if (out_valid) begin
        obs = {out_data, out_sof, out_eol, out_eof};
        checks++;
        if (got >= N) begin
          errors++; $display("FAIL stall_extra: got %h want no output", obs);
        end else begin
          if (obs !== ref_out[got]) begin
            errors++; $display("FAIL stall_beat%0d: got %h want %h", got, obs, ref_out[got]);
          end
          if (rdy) got++;
        end
      end
      ds_ready = rdy;
      if (sent < N) begin
        in_valid = 1'b1; in_sof = (sent == 0); in_data = pix_mem[sent]; in_mode = 2'd3;
      end else begin
        in_valid = 1'b0; in_sof = 1'b0;
      end
      #1;
      checks++;
      if (rdy_out !== (!out_valid || rdy)) begin
        errors++; $display("FAIL stall_ready: got %b want %b", rdy_out, (!out_valid || rdy));
      end
      if (in_valid && (!out_valid || rdy)) sent++;
    end
    in_valid = 1'b0; in_sof = 1'b0; ds_ready = 1'b1;
    checks++;
    if (got != N || sent != N) begin
      errors++; $display("FAIL stall_count: got %0d/%0d want %0d/%0d", sent, got, N, N);
    end
  endtask

  // SOF at (2,1) must restart at (0,0) with MID predictors, ignoring the line buffer.
  task automatic test_sof_mid();
    logic [23:0] px [8];
    logic        sf [8];
    px = '{24'h000000, 24'h000000, 24'h000000, 24'h000000,
           24'hFFFFFF, 24'hFFFFFF, 24'h808080, 24'h878787};
    sf = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ds_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k - 1 == 3) begin
        checks++;
        if ({out_valid, out_eol, out_eof} !== 3'b110) begin
          errors++; $display("FAIL sofmid_eol: got %b want 110", {out_valid, out_eol, out_eof});
        end
      end
      if (k - 1 == 6) begin
        checks++;
        if ({out_valid, out_data, out_sof} !== {1'b1, 16'h0000, 1'b1}) begin
          errors++; $display("FAIL sofmid_restart: got %h want %h",
            {out_valid, out_data, out_sof}, {1'b1, 16'h0000, 1'b1});
        end
      end
      if (k - 1 == 7) begin
        checks++;
        if ({out_valid, out_data, out_sof, out_eol} !== {1'b1, 16'h0841, 2'b00}) begin
          errors++; $display("FAIL sofmid_next: got %h want %h",
            {out_valid, out_data, out_sof, out_eol}, {1'b1, 16'h0841, 2'b00});
        end
      end
      if (k < 8) begin
        in_valid = 1'b1; in_sof = sf[k]; in_data = px[k]; in_mode = 2'd2;
      end else begin
        in_valid = 1'b0; in_sof = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    ds_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_sof = 1'b1; in_data = 24'h808080; in_mode = 2'd1;
    @(negedge clk);
    in_sof = 1'b0; in_data = 24'h818181;
    @(posedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_before: got %b want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data} !== {1'b0, 16'h0000}) begin
      errors++; $display("FAIL rstmid_clear: got %h want %h", {out_valid, out_data}, {1'b0, 16'h0000});
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // Counters back at (0,0) and mode back to average.
    send_one(24'hFF0000, 1'b0, 2'd0);
    checks++;
    if ({out_valid, out_data, out_sof} !== {1'b1, 16'h7C10, 1'b1}) begin
      errors++; $display("FAIL rstmid_after: got %h want %h",
        {out_valid, out_data, out_sof}, {1'b1, 16'h7C10, 1'b1});
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) pix_mem[i] = 24'($urandom);
    pix_mem[2] = 24'hFF00FF;
    pix_mem[5] = 24'h00FF00;
    test_reset();
    test_vectors();
    test_mode_hold();
    test_frame(1, 1'b0);
    test_frame(2, 1'b0);
    test_frame(3, 1'b1);
    test_stall();
    test_sof_mid();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
